framebuffer_frame_sequencer: RTL and testbench

//  Owns the write port and swap control of the double framebuffer, in the clk_write domain.
//  Per frame:
//   - optionally clears the back buffer to a colour;
//   - gives the write port to the renderer through a valid/ready pixel stream;
//   - on renderer frame_done, waits for VGA vsync (synchronised from clk_read), then pulses swap.

---
 rtl/color_pkg.sv | 4 +
 rtl/fb_seq_pkg.sv | 10 +
 rtl/framebuffer_frame_sequencer_sync_rise_detect.sv | 23 ++
 rtl/framebuffer_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_framebuffer_frame_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_pkg.sv
// Shared colour types for the video pipeline.
package color_pkg;
  typedef logic [11:0] color12_t;  // 4:4:4 RGB
endpackage

// File: rtl/fb_seq_pkg.sv
// Frame sequencer state encoding.
package fb_seq_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RENDER,
    WAIT_VSYNC,
    SWAP
  } fb_seq_state_t;
endpackage

// File: rtl/framebuffer_frame_sequencer_sync_rise_detect.sv
// Two-flop synchroniser for a level crossing into clk, plus a one-cycle rising-edge pulse.
module sync_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic r_meta, r_sync, r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise = r_sync & ~r_prev;
endmodule

// File: rtl/framebuffer_frame_sequencer.sv
// Owns the back-buffer write port and swap request: optional clear, renderer
// pixel stream, then a swap aligned to the next synchronised vsync rising edge.
module framebuffer_frame_sequencer
  import color_pkg::*;
  import fb_seq_pkg::*;
#(
  parameter int FB_WIDTH       = 160,
  parameter int FB_HEIGHT      = 120,
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic                         clk_write,
  input  logic                         rst,
  input  logic                         vsync_rd,
  input  logic                         frame_start,
  input  logic                         frame_done,
  input  color12_t                     clear_color,
  input  logic                         px_valid,
  output logic                         px_ready,
  input  logic [$clog2(FB_WIDTH)-1:0]  px_x,
  input  logic [$clog2(FB_HEIGHT)-1:0] px_y,
  input  color12_t                     px_color,
  output logic                         fb_write_enable,
  output logic [$clog2(FB_WIDTH)-1:0]  fb_write_x,
  output logic [$clog2(FB_HEIGHT)-1:0] fb_write_y,
  output color12_t                     fb_write_data,
  output logic                         fb_swap,
  output logic                         busy,
  output logic                         frame_swapped,
  output logic                         overrun
);
  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(FB_HEIGHT - 1);
  // One extra bit so the bound itself is representable for power-of-two sizes.
  localparam logic [XW:0]   X_LIM = (XW+1)'(FB_WIDTH);
  localparam logic [YW:0]   Y_LIM = (YW+1)'(FB_HEIGHT);

  fb_seq_state_t r_state, w_next;
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;
  color12_t      r_clr_color;
  logic          r_we;
  logic [XW-1:0] r_wx;
  logic [YW-1:0] r_wy;
  color12_t      r_wd;

  logic w_vsync_rise;
  logic w_clear_last;
  logic w_px_in_bounds;
  logic w_px_accept;

  sync_rise_detect u_vsync (
    .clk      (clk_write),
    .rst      (rst),
    .async_in (vsync_rd),
    .rise     (w_vsync_rise)
  );

  assign w_clear_last   = (r_cx == X_MAX) && (r_cy == Y_MAX);
  assign w_px_in_bounds = ({1'b0, px_x} < X_LIM) && ({1'b0, px_y} < Y_LIM);
  assign w_px_accept    = px_valid && px_ready;

  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:       if (frame_start) w_next = CLEAR_ON_START ? CLEAR : RENDER;
      CLEAR:      if (w_clear_last) w_next = RENDER;
      RENDER:     if (frame_done) w_next = WAIT_VSYNC;
      WAIT_VSYNC: if (w_vsync_rise) w_next = SWAP;
      SWAP:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  assign px_ready      = (r_state == RENDER);
  assign busy          = (r_state != IDLE);
  assign fb_swap       = (r_state == SWAP);
  assign frame_swapped = (r_state == SWAP);
  assign overrun       = frame_start && (r_state != IDLE);

  // Clear raster counters and the registered write port.
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      r_cx        <= '0;
      r_cy        <= '0;
      r_clr_color <= '0;
      r_we        <= 1'b0;
      r_wx        <= '0;
      r_wy        <= '0;
      r_wd        <= '0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_clr_color <= clear_color;
            r_cx        <= '0;
            r_cy        <= '0;
          end
        end
        CLEAR: begin
          r_we <= 1'b1;
          r_wx <= r_cx;
          r_wy <= r_cy;
          r_wd <= r_clr_color;
          if (r_cx == X_MAX) begin
            r_cx <= '0;
            if (r_cy != Y_MAX) r_cy <= r_cy + 1'b1;
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
        RENDER: begin
          // Out-of-range pixels are still handshaken so the renderer never stalls.
          if (w_px_accept && w_px_in_bounds) begin
            r_we <= 1'b1;
            r_wx <= px_x;
            r_wy <= px_y;
            r_wd <= px_color;
          end
        end
        default: ;
      endcase
    end
  end

  assign fb_write_enable = r_we;
  assign fb_write_x      = r_wx;
  assign fb_write_y      = r_wy;
  assign fb_write_data   = r_wd;
endmodule

// File: tb/tb_framebuffer_frame_sequencer.sv
// Randomised bench: expected write stream kept as a queue built from raster/bounds rules.
module tb_framebuffer_frame_sequencer;
  localparam int W = 4;
  localparam int H = 3;

  logic        clk_write = 1'b0;
  logic        rst;
  logic        vsync_rd, frame_start, frame_done, px_valid;
  logic [11:0] clear_color, px_color;
  logic [1:0]  px_x, px_y;
  logic        n_frame_start, n_frame_done, n_px_valid;

  logic        px_ready, fb_write_enable, fb_swap, busy, frame_swapped, overrun;
  logic [1:0]  fb_write_x, fb_write_y;
  logic [11:0] fb_write_data;
  logic        n_px_ready, n_fb_write_enable, n_fb_swap, n_busy, n_frame_swapped, n_overrun;
  logic [1:0]  n_fb_write_x, n_fb_write_y;
  logic [11:0] n_fb_write_data;

  always #5 clk_write = ~clk_write;

  framebuffer_frame_sequencer #(.FB_WIDTH(W), .FB_HEIGHT(H), .CLEAR_ON_START(1'b1)) dut (
    .clk_write(clk_write), .rst(rst), .vsync_rd(vsync_rd),
    .frame_start(frame_start), .frame_done(frame_done), .clear_color(clear_color),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .fb_write_enable(fb_write_enable), .fb_write_x(fb_write_x), .fb_write_y(fb_write_y),
    .fb_write_data(fb_write_data), .fb_swap(fb_swap), .busy(busy),
    .frame_swapped(frame_swapped), .overrun(overrun));

  framebuffer_frame_sequencer #(.FB_WIDTH(W), .FB_HEIGHT(H), .CLEAR_ON_START(1'b0)) dut_nc (
    .clk_write(clk_write), .rst(rst), .vsync_rd(vsync_rd),
    .frame_start(n_frame_start), .frame_done(n_frame_done), .clear_color(clear_color),
    .px_valid(n_px_valid), .px_ready(n_px_ready), .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .fb_write_enable(n_fb_write_enable), .fb_write_x(n_fb_write_x), .fb_write_y(n_fb_write_y),
    .fb_write_data(n_fb_write_data), .fb_swap(n_fb_swap), .busy(n_busy),
    .frame_swapped(n_frame_swapped), .overrun(n_overrun));

  int n_chk = 0, n_pass = 0;
  logic [15:0] exp_q[$];
  bit mon_en = 1'b0, swap_win = 1'b0;
  int n_wr_nc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_write); #1;
  endtask

  // Every write either matches the head of the expected queue or is flagged.
  always @(negedge clk_write) begin
    if (mon_en && !rst) begin
      if (fb_write_enable) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'(fb_write_enable), 32'd0);
        else chk("write", {fb_write_x, fb_write_y, fb_write_data}, exp_q.pop_front());
      end
      if (fb_swap && !swap_win) chk("stray_swap", 32'(fb_swap), 32'd0);
      if (fb_swap || frame_swapped) chk("swap_pair", 32'(frame_swapped), 32'(fb_swap));
      if (n_fb_write_enable) n_wr_nc++;
      if (n_fb_swap && !swap_win) chk("stray_swap_nc", 32'(n_fb_swap), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_out"}, {fb_write_enable, fb_write_x, fb_write_y, fb_write_data,
                        px_ready, fb_swap, busy, frame_swapped, overrun}, 32'd0);
  endtask

  task automatic begin_frame(input logic [11:0] c);
    frame_start = 1'b1;
    clear_color = c;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({2'(x), 2'(y), c});
    @(negedge clk_write);
    chk("overrun_idle", 32'(overrun), 32'd0);
    step();
    frame_start = 1'b0;
    clear_color = 12'($urandom);
  endtask

  task automatic clear_wait(input bit disturb);
    int n = 0;
    chk("ready_in_clear", 32'(px_ready), 32'd0);
    while (!px_ready && n < 40) begin
      if (disturb && n == 3) begin
        frame_start = 1'b1;
        clear_color = 12'h555;
        frame_done  = 1'b1;
        @(negedge clk_write);
        chk("overrun_pulse", 32'(overrun), 32'd1);
      end
      step();
      frame_start = 1'b0;
      frame_done  = 1'b0;
      n++;
    end
    chk("clear_len", n, 32'd12);
  endtask

  task automatic render_random(input int npix);
    for (int i = 0; i < npix; i++) begin
      px_valid = 1'($urandom_range(0, 1));
      px_x     = 2'($urandom_range(0, 3));
      px_y     = 2'($urandom_range(0, 3));
      px_color = 12'($urandom);
      vsync_rd = 1'($urandom_range(0, 1));
      if (px_valid && px_y < 2'(H)) exp_q.push_back({px_x, px_y, px_color});
      step();
    end
    px_valid = 1'b0;
    vsync_rd = 1'b0;
    repeat (3) step();
  endtask

  task automatic finish_frame(input bit with_px);
    int n = 0;
    frame_done = 1'b1;
    if (with_px) begin
      px_valid = 1'b1;
      px_x     = 2'($urandom_range(0, 3));
      px_y     = 2'($urandom_range(0, 2));
      px_color = 12'($urandom);
      exp_q.push_back({px_x, px_y, px_color});
    end
    step();
    frame_done = 1'b0;
    px_valid   = 1'b0;
    chk("ready_wait", 32'(px_ready), 32'd0);
    chk("busy_wait", 32'(busy), 32'd1);
    repeat (4) step();
    vsync_rd = 1'b1;
    swap_win = 1'b1;
    while (!fb_swap && n < 10) begin
      step();
      n++;
    end
    chk("swap_latency_ok", 32'(n == 3 || n == 4), 32'd1);
    chk("frame_swapped", 32'(frame_swapped), 32'd1);
    step();
    swap_win = 1'b0;
    chk("swap_one_cycle", 32'(fb_swap), 32'd0);
    chk("idle_after_swap", 32'(busy), 32'd0);
    vsync_rd = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1;
    {vsync_rd, frame_start, frame_done, px_valid} = '0;
    {n_frame_start, n_frame_done, n_px_valid} = '0;
    clear_color = '0; px_color = '0; px_x = '0; px_y = '0;
    step(); step();
    check_all_zero("reset");
    chk("reset_nc", {n_px_ready, n_busy, n_fb_write_enable, n_fb_swap, n_overrun}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Clear, directed render, out-of-range pixel, vsync during RENDER.
    begin_frame(12'hABC);
    clear_wait(1'b0);
    px_valid = 1'b1; px_x = 2'd2; px_y = 2'd1; px_color = 12'h0F0;
    exp_q.push_back({2'd2, 2'd1, 12'h0F0});
    step();
    px_valid = 1'b0;
    @(negedge clk_write);
    chk("render_write", {fb_write_enable, fb_write_x, fb_write_y, fb_write_data},
        {1'b1, 2'd2, 2'd1, 12'h0F0});
    step();
    px_valid = 1'b1; px_x = 2'd1; px_y = 2'd3; px_color = 12'hBAD;
    @(negedge clk_write);
    chk("oor_ready", 32'(px_ready), 32'd1);
    step();
    px_valid = 1'b0;
    @(negedge clk_write);
    chk("oor_no_write", 32'(fb_write_enable), 32'd0);
    step();
    vsync_rd = 1'b1;
    repeat (5) step();
    chk("render_ignores_vsync", {px_ready, busy}, 32'd3);
    render_random(30);
    finish_frame(1'b0);

    // Randomised frames, one with overrun and frame_done during CLEAR.
    for (int f = 0; f < 4; f++) begin
      begin_frame(12'($urandom));
      clear_wait(f == 1);
      render_random(20 + f * 5);
      finish_frame(f[0]);
    end

    // Reset mid-CLEAR.
    begin_frame(12'h123);
    repeat (5) step();
    #2 rst = 1'b1;
    #1 check_all_zero("rst_clear");
    exp_q.delete();
    step();
    rst = 1'b0;
    step();

    // Reset in WAIT_VSYNC.
    begin_frame(12'h321);
    clear_wait(1'b0);
    render_random(5);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    step(); step();
    chk("in_wait", {busy, px_ready}, 32'd2);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_wait");
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    vsync_rd = 1'b1;
    repeat (6) step();
    chk("no_swap_after_rst", {fb_swap, busy}, 32'd0);
    vsync_rd = 1'b0;
    repeat (3) step();

    begin_frame(12'hFED);
    clear_wait(1'b0);
    render_random(4);
    finish_frame(1'b1);
    chk("queue_drained", exp_q.size(), 32'd0);

    // CLEAR_ON_START=0 instance.
    begin
      int n = 0;
      n_frame_start = 1'b1;
      step();
      n_frame_start = 1'b0;
      chk("nc_ready", {n_px_ready, n_busy}, 32'd3);
      repeat (3) step();
      chk("nc_no_clear", n_wr_nc, 32'd0);
      n_px_valid = 1'b1; px_x = 2'd1; px_y = 2'd2; px_color = 12'h7E1;
      step();
      n_px_valid = 1'b0;
      @(negedge clk_write);
      chk("nc_write", {n_fb_write_enable, n_fb_write_x, n_fb_write_y, n_fb_write_data},
          {1'b1, 2'd1, 2'd2, 12'h7E1});
      step();
      n_frame_done = 1'b1;
      step();
      n_frame_done = 1'b0;
      repeat (3) step();
      vsync_rd = 1'b1;
      swap_win = 1'b1;
      while (!n_fb_swap && n < 10) begin
        step();
        n++;
      end
      chk("nc_swap", {n_fb_swap, n_frame_swapped}, 32'd3);
      step();
      swap_win = 1'b0;
      vsync_rd = 1'b0;
      chk("nc_idle", 32'(n_busy), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
